// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch
//
// Instruction fetch unit. Reads opcode and argument bytes from byte-wide
// program memory (non-pipelined req/ack) and assembles 16-bit instruction
// words {opcode, arg}. Opcode bit 7 set means a 2-byte instruction; clear
// means a 1-byte instruction whose arg is 8'h00. One instruction at a time
// is offered to the decoder under a valid/ready handshake. A redirect loads
// a new PC and abandons any fetch in progress.
//
// Optional feature macro: INST_FETCH_PREFETCH_EN
//   When defined, the unit fetches the next opcode byte into a 1-byte buffer
//   while holding an instruction. This allows back-to-back issue of 1-byte
//   instructions.
//
// Parameters:
//   ADDR_W       program address width, PC wraps modulo 2^ADDR_W
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   fetch_en     permits starting a new instruction fetch
//   mem_req      byte read request (combinational from state/pc/fetch_en)
//   mem_addr     byte address (always the current pc)
//   mem_ack      read complete this cycle (ignored unless mem_req)
//   mem_rdata    read data, valid with mem_ack
//   redirect     load redirect_pc as the new pc, flush everything
//   redirect_pc  new pc value
//   inst_valid   inst/inst_pc hold a complete instruction (registered)
//   inst         {opcode, arg} (registered)
//   inst_pc      address of the opcode byte (registered)
//   inst_ready   consumer accepts the instruction this cycle
// -----------------------------------------------------------------------------
module inst_fetch #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_en,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  output logic [15:0]       inst,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_ready
);

  typedef enum logic [1:0] {
    FETCH_HI = 2'd0,
    FETCH_LO = 2'd1,
    HOLD     = 2'd2
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [15:0]       inst_q;
  logic [ADDR_W-1:0] inst_pc_q;
  logic              inst_valid_q;

  logic [ADDR_W-1:0] pc_inc;
  logic              rd_done;

`ifdef INST_FETCH_PREFETCH_EN
  logic [7:0]        pbuf_q;
  logic              pbuf_full_q;
  logic [7:0]        nxt_op;
  logic [ADDR_W-1:0] nxt_op_pc;

  // Opcode for the next instruction on acceptance: the buffered byte if one
  // is held, otherwise the byte arriving this very cycle. A buffered byte was
  // read at pc-1 because pc already advanced past it.
  assign nxt_op    = pbuf_full_q ? pbuf_q : mem_rdata;
  assign nxt_op_pc = pbuf_full_q ? (pc_q - ADDR_W'(1)) : pc_q;
`endif

  assign pc_inc = pc_q + ADDR_W'(1);

  always_comb begin
    mem_req = 1'b0;
    case (state_q)
      FETCH_HI: mem_req = fetch_en;
      // A started instruction always completes, regardless of fetch_en.
      FETCH_LO: mem_req = 1'b1;
`ifdef INST_FETCH_PREFETCH_EN
      HOLD:     mem_req = fetch_en & ~pbuf_full_q;
`else
      HOLD:     mem_req = 1'b0;
`endif
      default:  mem_req = 1'b0;
    endcase
    // Keep the bus quiet while reset is held.
    if (rst) mem_req = 1'b0;
  end

  assign mem_addr = pc_q;
  // Acks that arrive without an outstanding request are ignored.
  assign rd_done  = mem_req & mem_ack;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= FETCH_HI;
      pc_q         <= '0;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      inst_valid_q <= 1'b0;
`ifdef INST_FETCH_PREFETCH_EN
      pbuf_q       <= '0;
      pbuf_full_q  <= 1'b0;
`endif
    end else if (redirect) begin
      // Redirect wins over everything; same-cycle read data is dropped.
      pc_q         <= redirect_pc;
      state_q      <= FETCH_HI;
      inst_valid_q <= 1'b0;
`ifdef INST_FETCH_PREFETCH_EN
      pbuf_full_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        FETCH_HI: begin
          if (rd_done) begin
            inst_q[15:8] <= mem_rdata;
            inst_pc_q    <= pc_q;
            pc_q         <= pc_inc;
            if (!mem_rdata[7]) begin
              inst_q[7:0]  <= 8'h00;
              state_q      <= HOLD;
              inst_valid_q <= 1'b1;
            end else begin
              state_q      <= FETCH_LO;
            end
          end
        end

        FETCH_LO: begin
          if (rd_done) begin
            inst_q[7:0]  <= mem_rdata;
            pc_q         <= pc_inc;
            state_q      <= HOLD;
            inst_valid_q <= 1'b1;
          end
        end

        HOLD: begin
`ifdef INST_FETCH_PREFETCH_EN
          if (inst_ready) begin
            if (pbuf_full_q || rd_done) begin
              // Next opcode is already available: start the next
              // instruction straight away.
              inst_q      <= {nxt_op, 8'h00};
              inst_pc_q   <= nxt_op_pc;
              pbuf_full_q <= 1'b0;
              if (!pbuf_full_q) pc_q <= pc_inc;
              if (nxt_op[7]) begin
                state_q      <= FETCH_LO;
                inst_valid_q <= 1'b0;
              end else begin
                state_q      <= HOLD;
                inst_valid_q <= 1'b1;
              end
            end else begin
              state_q      <= FETCH_HI;
              inst_valid_q <= 1'b0;
            end
          end else if (rd_done) begin
            pbuf_q      <= mem_rdata;
            pbuf_full_q <= 1'b1;
            pc_q        <= pc_inc;
          end
`else
          if (inst_ready) begin
            state_q      <= FETCH_HI;
            inst_valid_q <= 1'b0;
          end
`endif
        end

        default: begin
          state_q      <= FETCH_HI;
          inst_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign inst_valid = inst_valid_q;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;

endmodule
